// File: rtl/mem_stage.sv
// RV32I load/store stage: byte/half/word data-memory accesses over a valid/ready port, load extension, single-beat writeback.
// Optional feature: define MISALIGN_TRAP_EN to report misaligned H/W accesses instead of force-aligning them.
module mem_stage #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [XLEN-1:0]   ex_alu_result,
    input  logic [XLEN-1:0]   ex_store_data,
    input  logic [2:0]        ex_funct3,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic [4:0]        ex_rd,
    input  logic              ex_reg_write,
    output logic              dmem_req_valid,
    input  logic              dmem_req_ready,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic              dmem_we,
    output logic [3:0]        dmem_be,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic              dmem_rsp_valid,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [4:0]        wb_rd,
    output logic              wb_reg_write,
    output logic [XLEN-1:0]   wb_data,
    output logic              exc_misaligned,
    output logic [XLEN-1:0]   exc_addr
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] OUT  = 2'd3;

    logic [1:0]      state_r;
    logic            is_load_r;
    logic [1:0]      lane_r;
    logic [2:0]      funct3_r;
    logic            reg_write_r;

    logic            dmem_req_valid_r;
    logic [ADDR_W-1:0] dmem_addr_r;
    logic            dmem_we_r;
    logic [3:0]      dmem_be_r;
    logic [XLEN-1:0] dmem_wdata_r;
    logic            wb_valid_r;
    logic [4:0]      wb_rd_r;
    logic            wb_reg_write_r;
    logic [XLEN-1:0] wb_data_r;
    logic            exc_misaligned_r;
    logic [XLEN-1:0] exc_addr_r;

    logic            ex_ready_s;
    logic            accept_s;
    logic            is_mem_s;
    logic            misaligned_s;
    logic [1:0]      lane_s;

    // Byte lane after natural alignment; size field 1x is a word access.
    function automatic logic [1:0] lane_of(input logic [1:0] a, input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   lane_of = a;
            2'b01:   lane_of = {a[1], 1'b0};
            default: lane_of = 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [1:0] lane, input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   store_be = 4'b0001 << lane;
            2'b01:   store_be = 4'b0011 << lane;
            default: store_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [31:0] d, input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   store_data = {4{d[7:0]}};
            2'b01:   store_data = {2{d[15:0]}};
            default: store_data = d;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] rd, input logic [1:0] lane,
                                                input logic [2:0] f3);
        logic [7:0]  b;
        logic [15:0] h;
        case (lane)
            2'b00:   b = rd[7:0];
            2'b01:   b = rd[15:8];
            2'b10:   b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = lane[1] ? rd[31:16] : rd[15:0];
        case (f3[1:0])
            2'b00:   load_extend = f3[2] ? {24'h000000, b} : {{24{b[7]}}, b};
            2'b01:   load_extend = f3[2] ? {16'h0000, h} : {{16{h[15]}}, h};
            default: load_extend = rd;
        endcase
    endfunction

    // Misalignment detection for the incoming bundle.
    always_comb begin
`ifdef MISALIGN_TRAP_EN
        case (ex_funct3[1:0])
            2'b00:   misaligned_s = 1'b0;
            2'b01:   misaligned_s = ex_alu_result[0];
            default: misaligned_s = (ex_alu_result[1:0] != 2'b00);
        endcase
`else
        misaligned_s = 1'b0;
`endif
    end

    // Accept in IDLE, or in OUT when the current beat drains this cycle.
    always_comb begin
        if (state_r == IDLE) begin
            ex_ready_s = 1'b1;
        end else if (state_r == OUT) begin
            ex_ready_s = wb_ready;
        end else begin
            ex_ready_s = 1'b0;
        end
        accept_s = ex_valid && ex_ready_s;
        is_mem_s = ex_mem_read || ex_mem_write;
        lane_s   = lane_of(ex_alu_result[1:0], ex_funct3);
    end

    // Stage FSM and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r          <= IDLE;
            is_load_r        <= 1'b0;
            lane_r           <= 2'b00;
            funct3_r         <= 3'b000;
            reg_write_r      <= 1'b0;
            dmem_req_valid_r <= 1'b0;
            dmem_addr_r      <= '0;
            dmem_we_r        <= 1'b0;
            dmem_be_r        <= 4'b0000;
            dmem_wdata_r     <= '0;
            wb_valid_r       <= 1'b0;
            wb_rd_r          <= 5'd0;
            wb_reg_write_r   <= 1'b0;
            wb_data_r        <= '0;
            exc_misaligned_r <= 1'b0;
            exc_addr_r       <= '0;
        end else begin
            case (state_r)
                IDLE, OUT: begin
                    if (accept_s) begin
                        wb_rd_r          <= ex_rd;
                        exc_misaligned_r <= 1'b0;
                        exc_addr_r       <= '0;
                        if (!is_mem_s) begin
                            state_r        <= OUT;
                            wb_valid_r     <= 1'b1;
                            wb_data_r      <= ex_alu_result;
                            wb_reg_write_r <= ex_reg_write;
                        end else if (misaligned_s) begin
                            state_r          <= OUT;
                            wb_valid_r       <= 1'b1;
                            wb_data_r        <= '0;
                            wb_reg_write_r   <= 1'b0;
                            exc_misaligned_r <= 1'b1;
                            exc_addr_r       <= ex_alu_result;
                        end else begin
                            // A bundle flagged both read and write is handled as a load.
                            state_r          <= REQ;
                            wb_valid_r       <= 1'b0;
                            wb_reg_write_r   <= 1'b0;
                            is_load_r        <= ex_mem_read;
                            lane_r           <= lane_s;
                            funct3_r         <= ex_funct3;
                            reg_write_r      <= ex_reg_write;
                            dmem_req_valid_r <= 1'b1;
                            dmem_addr_r      <= {ex_alu_result[ADDR_W-1:2], 2'b00};
                            dmem_we_r        <= !ex_mem_read;
                            dmem_be_r        <= store_be(lane_s, ex_funct3);
                            dmem_wdata_r     <= store_data(ex_store_data, ex_funct3);
                        end
                    end else if ((state_r == OUT) && wb_ready) begin
                        state_r          <= IDLE;
                        wb_valid_r       <= 1'b0;
                        exc_misaligned_r <= 1'b0;
                    end else begin
                        state_r <= state_r;
                    end
                end
                REQ: begin
                    if (dmem_req_ready) begin
                        dmem_req_valid_r <= 1'b0;
                        if (is_load_r) begin
                            state_r <= WAIT;
                        end else begin
                            state_r        <= OUT;
                            wb_valid_r     <= 1'b1;
                            wb_reg_write_r <= 1'b0;
                        end
                    end else begin
                        state_r <= REQ;
                    end
                end
                WAIT: begin
                    if (dmem_rsp_valid) begin
                        state_r        <= OUT;
                        wb_valid_r     <= 1'b1;
                        wb_data_r      <= load_extend(dmem_rdata, lane_r, funct3_r);
                        wb_reg_write_r <= reg_write_r;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign ex_ready       = ex_ready_s;
    assign dmem_req_valid = dmem_req_valid_r;
    assign dmem_addr      = dmem_addr_r;
    assign dmem_we        = dmem_we_r;
    assign dmem_be        = dmem_be_r;
    assign dmem_wdata     = dmem_wdata_r;
    assign wb_valid       = wb_valid_r;
    assign wb_rd          = wb_rd_r;
    assign wb_reg_write   = wb_reg_write_r;
    assign wb_data        = wb_data_r;
    assign exc_misaligned = exc_misaligned_r;
    assign exc_addr       = exc_addr_r;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage; LW-misaligned expectations follow MISALIGN_TRAP_EN.
module tb_mem_stage;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_store_data;
    logic [2:0]  ex_funct3;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic [31:0] dmem_addr;
    logic        dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic [31:0] wb_data;
    logic        exc_misaligned;
    logic [31:0] exc_addr;

    int total = 0;
    int bad   = 0;

    mem_stage #(.XLEN(32), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
        .ex_funct3(ex_funct3), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd),
        .wb_reg_write(wb_reg_write), .wb_data(wb_data),
        .exc_misaligned(exc_misaligned), .exc_addr(exc_addr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic v, input logic [31:0] a, input logic [31:0] sd,
                          input logic [2:0] f3, input logic mr, input logic mw,
                          input logic [4:0] rd, input logic rw);
        ex_valid      = v;
        ex_alu_result = a;
        ex_store_data = sd;
        ex_funct3     = f3;
        ex_mem_read   = mr;
        ex_mem_write  = mw;
        ex_rd         = rd;
        ex_reg_write  = rw;
    endtask

    // Zero-wait load: request on accept+1, response in WAIT, writeback at accept+3.
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] exp_addr, input logic [31:0] rdata,
                           input logic [31:0] exp_data);
        set_ex(1'b1, a, 32'h0, f3, 1'b1, 1'b0, 5'd7, 1'b1);
        dmem_req_ready = 1'b1;
        tick();
        ex_valid = 1'b0;
        chk({tag, "_req_valid"}, {31'd0, dmem_req_valid}, 32'd1);
        chk({tag, "_addr"}, dmem_addr, exp_addr);
        chk({tag, "_we"}, {31'd0, dmem_we}, 32'd0);
        tick();
        chk({tag, "_wb_early"}, {31'd0, wb_valid}, 32'd0);
        dmem_rsp_valid = 1'b1;
        dmem_rdata     = rdata;
        tick();
        dmem_rsp_valid = 1'b0;
        chk({tag, "_wb_valid"}, {31'd0, wb_valid}, 32'd1);
        chk({tag, "_wb_data"}, wb_data, exp_data);
        chk({tag, "_wb_rd"}, {27'd0, wb_rd}, 32'd7);
        chk({tag, "_wb_rw"}, {31'd0, wb_reg_write}, 32'd1);
        tick();
        chk({tag, "_wb_drain"}, {31'd0, wb_valid}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        set_ex(1'b0, 32'h0, 32'h0, 3'b000, 1'b0, 1'b0, 5'd0, 1'b0);
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0;
        dmem_rdata     = 32'h0;
        wb_ready       = 1'b1;
        #3;
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_req_valid", {31'd0, dmem_req_valid}, 32'd0);
        chk("rst_be", {28'd0, dmem_be}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_exc", {31'd0, exc_misaligned}, 32'd0);
        chk("rst_ex_ready", {31'd0, ex_ready}, 32'd1);
        #9 rst_n = 1'b1;
        tick();

        // Non-memory pass-through
        set_ex(1'b1, 32'h1234, 32'h0, 3'b000, 1'b0, 1'b0, 5'd5, 1'b1);
        tick();
        ex_valid = 1'b0;
        chk("add_wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("add_wb_data", wb_data, 32'h1234);
        chk("add_wb_rd", {27'd0, wb_rd}, 32'd5);
        chk("add_wb_rw", {31'd0, wb_reg_write}, 32'd1);
        tick();
        chk("add_drain", {31'd0, wb_valid}, 32'd0);

        // Back-to-back non-memory ops, one per cycle
        set_ex(1'b1, 32'h11, 32'h0, 3'b000, 1'b0, 1'b0, 5'd1, 1'b1);
        tick();
        chk("b2b_a_data", wb_data, 32'h11);
        set_ex(1'b1, 32'h22, 32'h0, 3'b000, 1'b0, 1'b0, 5'd2, 1'b1);
        chk("b2b_ex_ready", {31'd0, ex_ready}, 32'd1);
        tick();
        ex_valid = 1'b0;
        chk("b2b_b_valid", {31'd0, wb_valid}, 32'd1);
        chk("b2b_b_data", wb_data, 32'h22);
        chk("b2b_b_rd", {27'd0, wb_rd}, 32'd2);
        tick();

        // SB to 0x103
        set_ex(1'b1, 32'h103, 32'hAB, 3'b000, 1'b0, 1'b1, 5'd3, 1'b1);
        dmem_req_ready = 1'b1;
        tick();
        ex_valid = 1'b0;
        chk("sb_req_valid", {31'd0, dmem_req_valid}, 32'd1);
        chk("sb_addr", dmem_addr, 32'h100);
        chk("sb_be", {28'd0, dmem_be}, 32'h8);
        chk("sb_wdata", dmem_wdata, 32'hABABABAB);
        chk("sb_we", {31'd0, dmem_we}, 32'd1);
        chk("sb_wb_early", {31'd0, wb_valid}, 32'd0);
        tick();
        chk("sb_wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("sb_wb_rw", {31'd0, wb_reg_write}, 32'd0);
        chk("sb_req_done", {31'd0, dmem_req_valid}, 32'd0);
        tick();

        // SH to 0x102
        set_ex(1'b1, 32'h102, 32'h1234CDEF, 3'b001, 1'b0, 1'b1, 5'd3, 1'b0);
        tick();
        ex_valid = 1'b0;
        chk("sh_be", {28'd0, dmem_be}, 32'hC);
        chk("sh_wdata", dmem_wdata, 32'hCDEFCDEF);
        chk("sh_addr", dmem_addr, 32'h100);
        tick();
        tick();

        // Loads with lane select and extension
        do_load("lb",  3'b000, 32'h102, 32'h100, 32'h0080FF00, 32'hFFFFFF80);
        do_load("lbu", 3'b100, 32'h102, 32'h100, 32'h0080FF00, 32'h00000080);
        do_load("lh",  3'b001, 32'h102, 32'h100, 32'h0080FF00, 32'h00000080);
        do_load("lh0", 3'b001, 32'h100, 32'h100, 32'h0080FF00, 32'hFFFFFF00);
        do_load("lhu", 3'b101, 32'h100, 32'h100, 32'h0080FF00, 32'h0000FF00);
        do_load("lw7", 3'b111, 32'h104, 32'h104, 32'h89ABCDEF, 32'h89ABCDEF);

        // Stalled load: req_ready low 3 cycles, one rsp wait cycle, wb_ready low 2 cycles
        set_ex(1'b1, 32'h200, 32'h0, 3'b010, 1'b1, 1'b0, 5'd9, 1'b1);
        dmem_req_ready = 1'b0;
        tick();
        ex_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stall_req_valid", {31'd0, dmem_req_valid}, 32'd1);
            chk("stall_req_addr", dmem_addr, 32'h200);
            chk("stall_req_be", {28'd0, dmem_be}, 32'hF);
            chk("stall_req_exr", {31'd0, ex_ready}, 32'd0);
            if (i == 2) dmem_req_ready = 1'b1;
            tick();
        end
        dmem_req_ready = 1'b0;
        chk("stall_wait_req", {31'd0, dmem_req_valid}, 32'd0);
        chk("stall_wait_exr", {31'd0, ex_ready}, 32'd0);
        tick();
        chk("stall_wait_wb", {31'd0, wb_valid}, 32'd0);
        dmem_rsp_valid = 1'b1;
        dmem_rdata     = 32'hDEADBEEF;
        wb_ready       = 1'b0;
        tick();
        dmem_rsp_valid = 1'b0;
        dmem_rdata     = 32'h0;
        for (int i = 0; i < 3; i++) begin
            chk("stall_wb_valid", {31'd0, wb_valid}, 32'd1);
            chk("stall_wb_data", wb_data, 32'hDEADBEEF);
            chk("stall_wb_rd", {27'd0, wb_rd}, 32'd9);
            if (i < 2) begin
                chk("stall_wb_exr", {31'd0, ex_ready}, 32'd0);
                tick();
            end else begin
                wb_ready = 1'b1;
                #1;
                chk("stall_hs_exr", {31'd0, ex_ready}, 32'd1);
            end
        end
        tick();
        chk("stall_drain", {31'd0, wb_valid}, 32'd0);

        // Reset during WAIT; a late response must not produce a writeback
        set_ex(1'b1, 32'h100, 32'h0, 3'b010, 1'b1, 1'b0, 5'd4, 1'b1);
        dmem_req_ready = 1'b1;
        tick();
        ex_valid = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("rstw_req_valid", {31'd0, dmem_req_valid}, 32'd0);
        chk("rstw_addr", dmem_addr, 32'd0);
        chk("rstw_be", {28'd0, dmem_be}, 32'd0);
        chk("rstw_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rstw_wb_rd", {27'd0, wb_rd}, 32'd0);
        #2 rst_n = 1'b1;
        tick();
        dmem_rsp_valid = 1'b1;
        dmem_rdata     = 32'h55AA55AA;
        tick();
        dmem_rsp_valid = 1'b0;
        chk("rstw_late_rsp", {31'd0, wb_valid}, 32'd0);
        tick();
        chk("rstw_late_rsp2", {31'd0, wb_valid}, 32'd0);

        // LW at misaligned 0x102
`ifdef MISALIGN_TRAP_EN
        set_ex(1'b1, 32'h102, 32'h0, 3'b010, 1'b1, 1'b0, 5'd6, 1'b1);
        tick();
        ex_valid = 1'b0;
        chk("mis_req_valid", {31'd0, dmem_req_valid}, 32'd0);
        chk("mis_wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("mis_exc", {31'd0, exc_misaligned}, 32'd1);
        chk("mis_exc_addr", exc_addr, 32'h102);
        chk("mis_wb_rw", {31'd0, wb_reg_write}, 32'd0);
        tick();
        chk("mis_drain", {31'd0, wb_valid}, 32'd0);
        chk("mis_no_req", {31'd0, dmem_req_valid}, 32'd0);
`else
        do_load("lw_mis", 3'b010, 32'h102, 32'h100, 32'h0080FF00, 32'h0080FF00);
        chk("lw_mis_exc", {31'd0, exc_misaligned}, 32'd0);
        chk("lw_mis_exc_addr", exc_addr, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
